// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
//   slot_t        : one tracked in-flight writer (EX..WB shadow entry)
//   FWD_RF        : bypass select value meaning "take operand from regfile"
//   clamp_rdy_stg : maps a raw ready-stage onto the legal range 1..DEPTH-1
// slot_t fields are sized for the widest supported configuration
// (REG_W <= HZ_RD_W, DEPTH <= 2**HZ_STG_W); narrower values are zero-extended.
package hazard_pkg;

    localparam int HZ_RD_W  = 8;
    localparam int HZ_STG_W = 4;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic [HZ_RD_W-1:0]  rd;
        logic [HZ_STG_W-1:0] rdy_stg;
    } slot_t;

    // A ready stage of 0 is meaningless (nothing is forwardable before EX
    // finishes), and anything past WB is only reachable through the regfile.
    function automatic logic [HZ_STG_W-1:0] clamp_rdy_stg(
        input logic [HZ_STG_W-1:0] stg,
        input logic [HZ_STG_W-1:0] max_stg
    );
        if (stg == '0)
            return HZ_STG_W'(1);
        else if (stg > max_stg)
            return max_stg;
        else
            return stg;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares one source register against a window of N tracked slots and
// reports the youngest (lowest-index) matching writer.
//   en      : source is real and actually read
//   src     : source register (zero-extended)
//   slots   : window of slots, element 0 is the youngest
//   hit     : a writer of src exists in the window
//   idx     : slot index of the youngest writer (window index + OFFSET), 0 if none
//   hit_rdy : ready stage of that writer
// Register 0 never matches.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int N      = 2,
    parameter int OFFSET = 0,
    parameter int IDX_W  = 2
) (
    input  logic                en,
    input  logic [HZ_RD_W-1:0]  src,
    input  slot_t               slots [N],
    output logic                hit,
    output logic [IDX_W-1:0]    idx,
    output logic [HZ_STG_W-1:0] hit_rdy
);

    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        hit_rdy = '0;
        // Scan oldest to youngest so the youngest match overwrites the rest.
        for (int i = N - 1; i >= 0; i--) begin
            if (en && (src != '0) && slots[i].valid && slots[i].regwrite &&
                (slots[i].rd == src)) begin
                hit     = 1'b1;
                idx     = IDX_W'(i + OFFSET);
                hit_rdy = slots[i].rdy_stg;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and load-use / multi-cycle hazard controller.
// Keeps a shadow shift chain of the writers in EX..WB (slot 0 = EX,
// slot DEPTH-1 = WB) and derives, combinationally:
//   fwd_sel : per EX source, 0 = regfile, k = bypass from slot k
//   stall   : hold PC/IF-ID and inject a bubble into EX
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   id_valid          ID instruction is real
//   id_regwrite/id_rd ID destination
//   id_rdy_stg        first slot at which the ID result is forwardable
//   id_src/id_src_use ID sources, src s at [s*REG_W +: REG_W]
//   flush             squash ID and EX (branch taken)
//   stall, fwd_sel    outputs as above
//   stall_cnt         saturating stall-cycle counter, only when
//                     HAZARD_PERF_CNT_EN is defined
// Supported range: 2 <= DEPTH <= 16, REG_W <= 8.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    localparam int SEL_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic                     id_regwrite,
    input  logic [REG_W-1:0]         id_rd,
    input  logic [SEL_W-1:0]         id_rdy_stg,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_use,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    slot_t                    slot_q [DEPTH];
    logic [NUM_SRC*REG_W-1:0] ex_src_q;
    logic [NUM_SRC-1:0]       ex_src_use_q;
    slot_t                    id_slot;

    always_comb begin
        id_slot.valid    = 1'b1;
        id_slot.regwrite = id_regwrite;
        id_slot.rd       = HZ_RD_W'(id_rd);
        id_slot.rdy_stg  = clamp_rdy_stg(HZ_STG_W'(id_rdy_stg), HZ_STG_W'(DEPTH - 1));
    end

    // Post-EX stages never stall, so everything past slot 0 shifts
    // unconditionally. Only the EX instruction's sources are ever looked at
    // again, so they are kept beside slot 0 instead of travelling down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                slot_q[k] <= '0;
            ex_src_q     <= '0;
            ex_src_use_q <= '0;
        end else begin
            for (int k = 2; k < DEPTH; k++)
                slot_q[k] <= slot_q[k-1];
            slot_q[1] <= flush ? '0 : slot_q[0];
            if (id_valid && !stall && !flush) begin
                slot_q[0]    <= id_slot;
                ex_src_q     <= id_src;
                ex_src_use_q <= id_src_use;
            end else begin
                slot_q[0]    <= '0;
                ex_src_use_q <= '0;
            end
        end
    end

    slot_t fwd_view   [DEPTH-1];
    slot_t stall_view [DEPTH-1];

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            fwd_view[i]   = slot_q[i+1];
            stall_view[i] = slot_q[i];
        end
    end

    logic                fwd_hit [NUM_SRC];
    logic [SEL_W-1:0]    fwd_idx [NUM_SRC];
    logic [HZ_STG_W-1:0] fwd_rdy [NUM_SRC];
    logic                st_hit  [NUM_SRC];
    logic [SEL_W-1:0]    st_idx  [NUM_SRC];
    logic [HZ_STG_W-1:0] st_rdy  [NUM_SRC];

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        // EX operand bypass: writers in MEM..WB.
        hazard_src_match #(
            .N      (DEPTH - 1),
            .OFFSET (1),
            .IDX_W  (SEL_W)
        ) u_fwd (
            .en      (slot_q[0].valid & ex_src_use_q[s]),
            .src     (HZ_RD_W'(ex_src_q[s*REG_W +: REG_W])),
            .slots   (fwd_view),
            .hit     (fwd_hit[s]),
            .idx     (fwd_idx[s]),
            .hit_rdy (fwd_rdy[s])
        );

        // ID hazard check: writers in EX..(WB-1); WB is covered by the
        // write-first regfile.
        hazard_src_match #(
            .N      (DEPTH - 1),
            .OFFSET (0),
            .IDX_W  (SEL_W)
        ) u_stall (
            .en      (id_valid & id_src_use[s]),
            .src     (HZ_RD_W'(id_src[s*REG_W +: REG_W])),
            .slots   (stall_view),
            .hit     (st_hit[s]),
            .idx     (st_idx[s]),
            .hit_rdy (st_rdy[s])
        );
    end

    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++)
            fwd_sel[s*SEL_W +: SEL_W] = fwd_hit[s] ? fwd_idx[s] : SEL_W'(FWD_RF);
    end

    // Writer in slot j reaches slot j+1 by the time this instruction is in
    // EX; stall unless its result is forwardable from there.
    logic [NUM_SRC-1:0] stall_need;

    always_comb begin
        stall_need = '0;
        for (int s = 0; s < NUM_SRC; s++)
            stall_need[s] = st_hit[s] &&
                            (st_rdy[s] > (HZ_STG_W'(st_idx[s]) + HZ_STG_W'(1)));
    end

    assign stall = (|stall_need) & ~flush;

    // The stall check guarantees a forwarded writer is always ready.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < NUM_SRC; s++)
                assert (!(fwd_hit[s] && (fwd_rdy[s] > HZ_STG_W'(fwd_idx[s]))));
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int SEL_W   = 2;
    localparam int MAXC    = 4096;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     id_valid = 1'b0;
    logic                     id_regwrite = 1'b0;
    logic [REG_W-1:0]         id_rd = '0;
    logic [SEL_W-1:0]         id_rdy_stg = '0;
    logic [NUM_SRC*REG_W-1:0] id_src = '0;
    logic [NUM_SRC-1:0]       id_src_use = '0;
    logic                     flush = 1'b0;
    logic                     stall;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]              stall_cnt;
`endif

    always #5 clk = ~clk;

    hazard_forward_ctrl #(
        .REG_W   (REG_W),
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_regwrite (id_regwrite),
        .id_rd       (id_rd),
        .id_rdy_stg  (id_rdy_stg),
        .id_src      (id_src),
        .id_src_use  (id_src_use),
        .flush       (flush),
        .stall       (stall),
        .fwd_sel     (fwd_sel)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // Reference model: a history of which instruction entered EX in each
    // cycle. An instruction that entered EX in cycle t sits in stage c-t
    // during cycle c, unless a flush in cycle t squashed it on its way out.
    typedef struct {
        bit valid;
        bit rw;
        int rd;
        int rdy;
        int src [2];
        bit used [2];
    } minst_t;

    minst_t hist [MAXC];
    bit     killed [MAXC];
    minst_t bubble;
    int     cyc = 0;
    int     perf_exp = 0;
    int     n_assert = 0;
    int     n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_assert++;
        assert (obs === 32'(exp))
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampr(input int r);
        if (r < 1) return 1;
        if (r > DEPTH - 1) return DEPTH - 1;
        return r;
    endfunction

    function automatic minst_t mk(input bit v, input bit rw, input int rd, input int rdy,
                                  input int s0, input int s1, input bit u0, input bit u1);
        minst_t m;
        m.valid = v; m.rw = rw; m.rd = rd; m.rdy = rdy;
        m.src[0] = s0; m.src[1] = s1; m.used[0] = u0; m.used[1] = u1;
        return m;
    endfunction

    function automatic bit alive(input int t);
        return (t >= 0) && hist[t].valid && !killed[t];
    endfunction

    // Youngest older writer in MEM..WB of the EX instruction's source s.
    function automatic int model_fwd(input int s);
        minst_t ex;
        ex = hist[cyc];
        if (!ex.valid || !ex.used[s] || ex.src[s] == 0) return 0;
        for (int k = 1; k < DEPTH; k++)
            if (alive(cyc - k) && hist[cyc-k].rw && hist[cyc-k].rd == ex.src[s])
                return k;
        return 0;
    endfunction

    function automatic bit model_stall(input minst_t id, input bit fl);
        if (!id.valid || fl) return 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (id.used[s] && id.src[s] != 0) begin
                for (int j = 0; j <= DEPTH - 2; j++) begin
                    if (alive(cyc - j) && hist[cyc-j].rw && hist[cyc-j].rd == id.src[s]) begin
                        if (clampr(hist[cyc-j].rdy) > j + 1) return 1'b1;
                        break;
                    end
                end
            end
        end
        return 1'b0;
    endfunction

    // One clock: drive ID at negedge, check at negedge+1, advance model at posedge.
    // e_st/e0/e1 >= 0 add hand-derived expectations for directed steps.
    task automatic cycle(input minst_t in, input bit fl, input int e_st, input int e0,
                         input int e1, input string tag, output bit st_o);
        bit st;
        @(negedge clk);
        id_valid    = in.valid;
        id_regwrite = in.rw;
        id_rd       = REG_W'(in.rd);
        id_rdy_stg  = SEL_W'(in.rdy);
        id_src      = {REG_W'(in.src[1]), REG_W'(in.src[0])};
        id_src_use  = {in.used[1], in.used[0]};
        flush       = fl;
        #1;
        st = model_stall(in, fl);
        chk({tag, "/stall"}, 32'(stall), int'(st));
        chk({tag, "/sel0"}, 32'(fwd_sel[1:0]), model_fwd(0));
        chk({tag, "/sel1"}, 32'(fwd_sel[3:2]), model_fwd(1));
        if (e_st >= 0) chk({tag, "/stall_dir"}, 32'(stall), e_st);
        if (e0 >= 0) chk({tag, "/sel0_dir"}, 32'(fwd_sel[1:0]), e0);
        if (e1 >= 0) chk({tag, "/sel1_dir"}, 32'(fwd_sel[3:2]), e1);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "/stall_cnt"}, stall_cnt, perf_exp);
`endif
        @(posedge clk);
        if (st) perf_exp++;
        killed[cyc] = fl;
        hist[cyc+1] = (in.valid && !st && !fl) ? in : bubble;
        killed[cyc+1] = 1'b0;
        cyc++;
        st_o = st;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; id_src_use = '0;
        #1;
        chk({tag, "/stall"}, 32'(stall), 0);
        chk({tag, "/fwd_sel"}, 32'(fwd_sel), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "/stall_cnt"}, stall_cnt, 0);
`endif
        for (int i = 0; i <= cyc + 3; i++) begin
            hist[i] = bubble;
            killed[i] = 1'b0;
        end
        perf_exp = 0;
        @(posedge clk); cyc++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); cyc++;
    endtask

    function automatic minst_t rnd_inst();
        return mk($urandom % 5 != 0, $urandom % 10 < 7, $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom % 2), 1'($urandom % 2));
    endfunction

    initial begin
        minst_t nop, cons, ld, cur;
        bit st, fl;
        bubble = mk(0, 0, 0, 0, 0, 0, 0, 0);
        nop = bubble;
        for (int i = 0; i < MAXC; i++) begin
            hist[i] = bubble;
            killed[i] = 1'b0;
        end

        do_reset("reset");

        // ALU r3 then immediate consumer of r3 as src0
        cycle(mk(1, 1, 3, 1, 1, 2, 1, 1), 0, 0, 0, 0, "alu_r3", st);
        cycle(mk(1, 1, 4, 1, 3, 0, 1, 0), 0, 0, -1, -1, "use_r3_id", st);
        cycle(nop, 0, -1, 1, 0, "use_r3_ex", st);

        // ALU r6, independent, consumer uses r6 as src1
        cycle(mk(1, 1, 6, 1, 1, 2, 0, 0), 0, -1, -1, -1, "alu_r6", st);
        cycle(mk(1, 1, 7, 1, 1, 2, 0, 0), 0, -1, -1, -1, "indep", st);
        cycle(mk(1, 1, 9, 1, 0, 6, 1, 1), 0, 0, -1, -1, "use_r6_id", st);
        cycle(nop, 0, -1, 0, 2, "use_r6_ex", st);

        // two writers of r8: youngest (MEM) wins
        cycle(mk(1, 1, 8, 1, 0, 0, 0, 0), 0, -1, -1, -1, "wr8_a", st);
        cycle(mk(1, 1, 8, 1, 0, 0, 0, 0), 0, -1, -1, -1, "wr8_b", st);
        cycle(mk(1, 1, 10, 1, 8, 0, 1, 0), 0, 0, -1, -1, "use_r8_id", st);
        cycle(nop, 0, -1, 1, 0, "use_r8_ex", st);

        // load-use: one bubble, then bypass from WB
        ld   = mk(1, 1, 5, 2, 0, 0, 0, 0);
        cons = mk(1, 1, 11, 1, 5, 0, 1, 0);
        cycle(ld, 0, -1, -1, -1, "load_r5", st);
        cycle(cons, 0, 1, 0, 0, "lu_stall", st);
        cycle(cons, 0, 0, -1, -1, "lu_release", st);
        cycle(nop, 0, -1, 2, 0, "lu_fwd", st);

        // writer of r0 never forwards or stalls
        cycle(mk(1, 1, 0, 2, 0, 0, 0, 0), 0, -1, -1, -1, "wr_r0", st);
        cycle(mk(1, 1, 12, 1, 0, 0, 1, 1), 0, 0, -1, -1, "r0_id", st);
        cycle(nop, 0, -1, 0, 0, "r0_ex", st);

        // flush in the would-be stall cycle squashes load and consumer
        cycle(ld, 0, -1, -1, -1, "fl_load", st);
        cycle(cons, 1, 0, -1, -1, "fl_stall", st);
        cycle(cons, 0, 0, 0, 0, "fl_after", st);
        cycle(nop, 0, -1, 0, 0, "fl_ex", st);

        // reset mid-stream discards in-flight r3 writer
        cycle(mk(1, 1, 3, 1, 0, 0, 0, 0), 0, -1, -1, -1, "pre_rst", st);
        do_reset("mid_reset");
        cycle(mk(1, 1, 13, 1, 3, 3, 1, 1), 0, 0, -1, -1, "post_rst_id", st);
        cycle(nop, 0, -1, 0, 0, "post_rst_ex", st);

        // three load-use pairs -> three stall cycles
        for (int p = 0; p < 3; p++) begin
            cycle(ld, 0, -1, -1, -1, "perf_load", st);
            cycle(cons, 0, 1, -1, -1, "perf_stall", st);
            cycle(cons, 0, 0, -1, -1, "perf_go", st);
        end
        cycle(nop, 0, -1, -1, -1, "perf_idle", st);
`ifdef HAZARD_PERF_CNT_EN
        #2;
        chk("perf_cnt3", stall_cnt, 3);
`endif

        // randomized traffic, ID held while stalled
        cur = rnd_inst();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                do_reset("rnd_reset");
                cur = rnd_inst();
            end
            fl = ($urandom % 10 == 0);
            cycle(cur, fl, -1, -1, -1, "rnd", st);
            if (!st || fl) cur = rnd_inst();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
